// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants and encodings for the instruction/data memory port arbiter.
// No logic; types only.
// No backpressure; types only.
package mem_port_arbiter_pkg;

    // Word-width constants (AW/DW) shared with the processor.
    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    localparam int CNT_W  = 3;
    localparam int RUN_W  = 4;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_port_arbiter_rr_guard.sv
// Fetch anti-starvation guard: counts consecutive data grants while fetch waits.
// force_if is registered-derived, valid in the same cycle as the requests.
// No backpressure; run clears whenever fetch stops asking or is served.
module rr_guard
    import mem_port_arbiter_pkg::*;
#(
    parameter int MAXRUN = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic if_req,
    input  logic d_gnt,
    input  logic if_gnt,
    output logic force_if
);

    logic [RUN_W-1:0] run;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run <= '0;
        end else if (!if_req || if_gnt) begin
            run <= '0;
        end else if (d_gnt && (run != RUN_W'(MAXRUN))) begin
            run <= run + RUN_W'(1);
        end
    end

    assign force_if = (run == RUN_W'(MAXRUN));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one fixed-latency single-ported memory between fetch and load/store.
// Grant is combinational; response rvalid arrives LAT cycles after the grant.
// Requesters hold req until gnt; one access in flight, gnt=0 while busy.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW     = ADDR_W,
    parameter int DW     = DATA_W,
    parameter int LAT    = 2,
    parameter int MAXRUN = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    owner_t           owner, owner_nxt;
    logic             own_we, own_we_nxt;
    logic             grant_if, grant_d;
    logic             capture;
    owner_t           cap_owner;
    logic             cap_we;
    logic             force_if;

    rr_guard #(
        .MAXRUN (MAXRUN)
    ) u_rr_guard (
        .clk      (clk),
        .reset    (reset),
        .if_req   (if_req),
        .d_gnt    (grant_d),
        .if_gnt   (grant_if),
        .force_if (force_if)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            owner  <= OWN_IF;
            own_we <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            owner  <= owner_nxt;
            own_we <= own_we_nxt;
        end
    end

    // cnt holds the remaining WAIT cycles: the grant cycle itself is the first of LAT.
    always_comb begin
        grant_if   = 1'b0;
        grant_d    = 1'b0;
        state_nxt  = state;
        cnt_nxt    = cnt;
        owner_nxt  = owner;
        own_we_nxt = own_we;
        capture    = 1'b0;
        cap_owner  = owner;
        cap_we     = own_we;
        case (state)
            IDLE: begin
                if (if_req && (!d_req || force_if)) begin
                    grant_if = 1'b1;
                end else if (d_req) begin
                    grant_d = 1'b1;
                end
                if (grant_if || grant_d) begin
                    owner_nxt  = grant_d ? OWN_D : OWN_IF;
                    own_we_nxt = grant_d & d_we;
                    if (LAT == 1) begin
                        capture   = 1'b1;
                        cap_owner = owner_nxt;
                        cap_we    = own_we_nxt;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt   = CNT_W'(LAT - 1);
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    capture   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            if (capture) begin
                if (cap_owner == OWN_D) begin
                    d_rvalid <= 1'b1;
                    d_rdata  <= cap_we ? '0 : mem_rdata;
                end else begin
                    if_rvalid <= 1'b1;
                    if_rdata  <= mem_rdata;
                end
            end
        end
    end

    assign if_gnt    = grant_if;
    assign d_gnt     = grant_d;
    assign mem_en    = grant_if | grant_d;
    assign mem_we    = grant_d & d_we;
    assign mem_addr  = grant_d ? d_addr : (grant_if ? if_addr : '0);
    assign mem_wdata = (grant_d & d_we) ? d_wdata : '0;
    assign busy      = (state == WAIT);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: LAT=2 instance for directed traffic, LAT=1 instance for back-to-back fetch.
module tb_mem_port_arbiter;

    typedef struct packed {
        logic        own;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
    } gnt_t;

    typedef struct packed {
        logic        own;
        logic [15:0] data;
    } rsp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int rsp_seen = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // LAT=2 instance
    logic        if_req = 0, d_req = 0, d_we = 0;
    logic [15:0] if_addr = 0, d_addr = 0, d_wdata = 0;
    logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we, busy;
    logic [15:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [15:0] mema [0:255];
    logic [15:0] rdq = 0;

    mem_port_arbiter #(.AW(16), .DW(16), .LAT(2), .MAXRUN(4)) dut_a (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    // One register stage: data visible in cycle t+1, sampled by the arbiter at its end.
    always @(posedge clk) begin
        if (mem_en && mem_we) mema[mem_addr[7:0]] <= mem_wdata;
        if (mem_en && !mem_we) rdq <= mema[mem_addr[7:0]];
    end
    assign mem_rdata = rdq;

    // LAT=1 instance with combinational memory read
    logic        if_req_b = 0;
    logic [15:0] if_addr_b = 0;
    logic        d_req_b = 0, d_we_b = 0;
    logic [15:0] d_addr_b = 0, d_wdata_b = 0;
    logic        if_gnt_b, if_rvalid_b, d_gnt_b, d_rvalid_b, mem_en_b, mem_we_b, busy_b;
    logic [15:0] if_rdata_b, d_rdata_b, mem_addr_b, mem_wdata_b, mem_rdata_b;
    logic [15:0] memb [0:255];

    mem_port_arbiter #(.AW(16), .DW(16), .LAT(1), .MAXRUN(4)) dut_b (
        .clk(clk), .reset(reset),
        .if_req(if_req_b), .if_addr(if_addr_b), .if_gnt(if_gnt_b),
        .if_rvalid(if_rvalid_b), .if_rdata(if_rdata_b),
        .d_req(d_req_b), .d_we(d_we_b), .d_addr(d_addr_b), .d_wdata(d_wdata_b),
        .d_gnt(d_gnt_b), .d_rvalid(d_rvalid_b), .d_rdata(d_rdata_b),
        .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
        .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b), .busy(busy_b)
    );
    assign mem_rdata_b = memb[mem_addr_b[7:0]];

    gnt_t exp_gnt[$];
    rsp_t exp_rsp[$];
    rsp_t exp_rsp_b[$];
    int   gcyc_a[$];
    int   gcyc_b[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp)
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        else
            passes++;
    endtask

    // Monitor A: grants against exp_gnt, responses against exp_rsp and latency.
    always @(negedge clk) begin
        gnt_t eg;
        rsp_t er;
        if (!reset) begin
            gcyc_a.delete();
        end else begin
            if (mem_en) begin
                check("a single gnt", {63'b0, if_gnt ^ d_gnt}, 64'd1);
                if (exp_gnt.size() == 0) begin
                    check("a unexpected grant", 64'd0, 64'd1);
                end else begin
                    eg = exp_gnt.pop_front();
                    check("a gnt owner", {63'b0, d_gnt}, {63'b0, eg.own});
                    check("a mem_we", {63'b0, mem_we}, {63'b0, eg.we});
                    check("a mem_addr", {48'b0, mem_addr}, {48'b0, eg.addr});
                    check("a mem_wdata", {48'b0, mem_wdata}, {48'b0, eg.wdata});
                end
                gcyc_a.push_back(cyc);
            end else begin
                check("a idle bus", {29'b0, if_gnt, d_gnt, mem_we, mem_addr, mem_wdata}, 64'd0);
            end
            if (if_rvalid || d_rvalid) begin
                rsp_seen++;
                check("a rvalid both", {63'b0, if_rvalid & d_rvalid}, 64'd0);
                if (exp_rsp.size() == 0) begin
                    check("a unexpected rsp", 64'd0, 64'd1);
                end else begin
                    er = exp_rsp.pop_front();
                    check("a rsp port", {63'b0, d_rvalid}, {63'b0, er.own});
                    check("a rsp data", {48'b0, (d_rvalid ? d_rdata : if_rdata)}, {48'b0, er.data});
                end
                if (gcyc_a.size() == 0) check("a rsp without grant", 64'd0, 64'd1);
                else check("a latency", 64'(cyc - gcyc_a.pop_front()), 64'd2);
            end
        end
    end

    // Monitor B: fetch responses of the LAT=1 instance.
    always @(negedge clk) begin
        rsp_t er;
        if (!reset) begin
            gcyc_b.delete();
        end else begin
            if (mem_en_b) gcyc_b.push_back(cyc);
            if (d_rvalid_b) check("b unexpected d_rvalid", 64'd1, 64'd0);
            if (if_rvalid_b) begin
                if (exp_rsp_b.size() == 0) begin
                    check("b unexpected rsp", 64'd0, 64'd1);
                end else begin
                    er = exp_rsp_b.pop_front();
                    check("b rsp data", {48'b0, if_rdata_b}, {48'b0, er.data});
                end
                if (gcyc_b.size() == 0) check("b rsp without grant", 64'd0, 64'd1);
                else check("b latency", 64'(cyc - gcyc_b.pop_front()), 64'd1);
            end
        end
    end

    // Returns at posedge+1 of the cycle after the grant.
    task automatic d_access(input logic we, input logic [15:0] addr, input logic [15:0] wdata);
        int n;
        @(posedge clk); #1;
        d_req = 1; d_we = we; d_addr = addr; d_wdata = wdata;
        n = 0;
        do begin @(negedge clk); n++; end while (!d_gnt && n < 50);
        if (!d_gnt) check("d_gnt timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    endtask

    task automatic f_access(input logic [15:0] addr);
        int n;
        @(posedge clk); #1;
        if_req = 1; if_addr = addr;
        n = 0;
        do begin @(negedge clk); n++; end while (!if_gnt && n < 50);
        if (!if_gnt) check("if_gnt timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        if_req = 0; if_addr = 0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_rsp.size() != 0 || exp_gnt.size() != 0 || exp_rsp_b.size() != 0) && n < 50) begin
            @(negedge clk); n++;
        end
        check("drain queues", 64'(exp_rsp.size() + exp_gnt.size() + exp_rsp_b.size()), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, seen0, last_g, ng;
        for (int i = 0; i < 256; i++) begin
            mema[i] = 16'h0;
            memb[i] = 16'hA000 + 16'(i);
        end
        mema[8'h10] = 16'hBEEF;
        mema[8'h30] = 16'h3333;
        mema[8'h40] = 16'h4444;
        mema[8'h50] = 16'h5555;
        mema[8'h60] = 16'h6666;

        // Reset state
        repeat (2) @(negedge clk);
        check("reset outputs", {26'b0, if_rvalid, d_rvalid, busy, mem_en, mem_we, if_gnt, d_gnt, if_rdata, d_rdata}, 64'd0);
        @(posedge clk); #1 reset = 1;
        @(negedge clk);
        check("post-reset outputs", {29'b0, if_rvalid, d_rvalid, busy, if_rdata, d_rdata}, 64'd0);

        // Single load
        exp_gnt.push_back('{own:1'b1, we:1'b0, addr:16'h0010, wdata:16'h0});
        exp_rsp.push_back('{own:1'b1, data:16'hBEEF});
        d_access(1'b0, 16'h0010, 16'h0);
        check("busy in wait", {63'b0, busy}, 64'd1);
        drain();

        // Store then fetch
        exp_gnt.push_back('{own:1'b1, we:1'b1, addr:16'h0020, wdata:16'h1234});
        exp_rsp.push_back('{own:1'b1, data:16'h0000});
        exp_gnt.push_back('{own:1'b0, we:1'b0, addr:16'h0020, wdata:16'h0});
        exp_rsp.push_back('{own:1'b0, data:16'h1234});
        d_access(1'b1, 16'h0020, 16'h1234);
        f_access(16'h0020);
        drain();

        // Contention: D,D,D,D,IF repeating, one grant every 2 cycles
        for (int k = 0; k < 10; k++) begin
            if (k == 4 || k == 9) begin
                exp_gnt.push_back('{own:1'b0, we:1'b0, addr:16'h0030, wdata:16'h0});
                exp_rsp.push_back('{own:1'b0, data:16'h3333});
            end else begin
                exp_gnt.push_back('{own:1'b1, we:1'b0, addr:16'h0040, wdata:16'h0});
                exp_rsp.push_back('{own:1'b1, data:16'h4444});
            end
        end
        @(posedge clk); #1;
        if_req = 1; if_addr = 16'h0030; d_req = 1; d_we = 0; d_addr = 16'h0040; d_wdata = 0;
        ng = 0; n = 0; last_g = 0;
        while (ng < 10 && n < 100) begin
            @(negedge clk); n++;
            if (mem_en) begin
                if (ng > 0) check("contention gap", 64'(cyc - last_g), 64'd2);
                last_g = cyc;
                ng++;
            end
        end
        check("contention grant count", 64'(ng), 64'd10);
        @(posedge clk); #1;
        if_req = 0; if_addr = 0; d_req = 0; d_addr = 0;
        drain();

        // Reset one cycle after a load grant
        exp_gnt.push_back('{own:1'b1, we:1'b0, addr:16'h0050, wdata:16'h0});
        d_access(1'b0, 16'h0050, 16'h0);
        seen0 = rsp_seen;
        check("busy before reset", {63'b0, busy}, 64'd1);
        reset = 0;
        #1;
        check("busy async clear", {63'b0, busy}, 64'd0);
        check("mem_en in reset", {63'b0, mem_en}, 64'd0);
        @(posedge clk); #1 reset = 1;
        repeat (4) @(negedge clk);
        check("no rsp after reset", 64'(rsp_seen - seen0), 64'd0);
        exp_gnt.push_back('{own:1'b1, we:1'b0, addr:16'h0010, wdata:16'h0});
        exp_rsp.push_back('{own:1'b1, data:16'hBEEF});
        d_access(1'b0, 16'h0010, 16'h0);
        drain();

        // Fetch request withdrawn while busy
        exp_gnt.push_back('{own:1'b1, we:1'b0, addr:16'h0060, wdata:16'h0});
        exp_rsp.push_back('{own:1'b1, data:16'h6666});
        d_access(1'b0, 16'h0060, 16'h0);
        if_req = 1; if_addr = 16'h0070;
        @(negedge clk);
        check("withdrawn if_gnt", {62'b0, if_gnt, mem_en}, 64'd0);
        @(posedge clk); #1;
        if_req = 0; if_addr = 0;
        drain();

        // LAT=1 back-to-back fetches, addresses 0..3
        for (int i = 0; i < 4; i++) exp_rsp_b.push_back('{own:1'b0, data:16'hA000 + 16'(i)});
        @(posedge clk); #1;
        if_req_b = 1; if_addr_b = 16'h0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("b if_gnt every cycle", {63'b0, if_gnt_b}, 64'd1);
            @(posedge clk); #1;
            if_addr_b = 16'(i + 1);
        end
        if_req_b = 0; if_addr_b = 0;
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
